// File: rtl/axi_arbiter_if.sv
// Signal bundle between the fetch/load-store requesters, the arbiter and the AXI slave.
// The master modport is the arbiter's view; slave is the environment's view.
interface axi_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_done;

  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic [31:0] data_rdata;
  logic        data_done;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  logic        stallreq_axi;

  modport master (
    input  inst_req, inst_addr,
    output inst_rdata, inst_done,
    input  data_req, data_wr, data_addr, data_wdata, data_wstrb,
    output data_rdata, data_done,
    output araddr, arvalid,
    input  arready, rdata, rvalid,
    output rready, awaddr, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready, bvalid,
    output bready, stallreq_axi
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_rdata, inst_done,
    output data_req, data_wr, data_addr, data_wdata, data_wstrb,
    input  data_rdata, data_done,
    input  araddr, arvalid,
    output arready, rdata, rvalid,
    input  rready, awaddr, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready, bvalid,
    input  bready, stallreq_axi
  );
endinterface

// File: rtl/axi_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto a single AXI port, one transaction
// outstanding; load/store wins ties, completion is reported with a one-cycle done pulse.
module axi_arbiter (
  input  logic          clk,
  input  logic          rst,
  axi_arbiter_if.master bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ADDR = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR_ADDR = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;

  logic [2:0] state;
  logic       id_data;
  logic       aw_pend;
  logic       w_pend;
  logic       inst_pending;
  logic       data_pending;

  // A requester still high during its own done cycle is finishing, not asking again.
  assign inst_pending     = bus.inst_req && !bus.inst_done;
  assign data_pending     = bus.data_req && !bus.data_done;
  assign bus.stallreq_axi = inst_pending || data_pending;

  assign bus.arvalid = (state == RD_ADDR);
  assign bus.rready  = (state == RD_DATA);
  assign bus.awvalid = (state == WR_ADDR) && aw_pend;
  assign bus.wvalid  = (state == WR_ADDR) && w_pend;
  assign bus.bready  = (state == WR_RESP);

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; the read-data registers are plain flops and are reset too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      id_data        <= 1'b0;
      aw_pend        <= 1'b0;
      w_pend         <= 1'b0;
      bus.inst_done  <= 1'b0;
      bus.data_done  <= 1'b0;
      bus.inst_rdata <= '0;
      bus.data_rdata <= '0;
      bus.araddr     <= '0;
      bus.awaddr     <= '0;
      bus.wdata      <= '0;
      bus.wstrb      <= '0;
    end else begin
      bus.inst_done <= 1'b0;
      bus.data_done <= 1'b0;
      case (state)
        IDLE: begin
          if (data_pending) begin
            id_data <= 1'b1;
            if (bus.data_wr) begin
              bus.awaddr <= bus.data_addr;
              bus.wdata  <= bus.data_wdata;
              bus.wstrb  <= bus.data_wstrb;
              aw_pend    <= 1'b1;
              w_pend     <= 1'b1;
              state      <= WR_ADDR;
            end else begin
              bus.araddr <= bus.data_addr;
              state      <= RD_ADDR;
            end
          end else if (inst_pending) begin
            id_data    <= 1'b0;
            bus.araddr <= bus.inst_addr;
            state      <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (bus.arready) state <= RD_DATA;
        end
        RD_DATA: begin
          if (bus.rvalid) begin
            if (id_data) begin
              bus.data_rdata <= bus.rdata;
              bus.data_done  <= 1'b1;
            end else begin
              bus.inst_rdata <= bus.rdata;
              bus.inst_done  <= 1'b1;
            end
            state <= IDLE;
          end
        end
        WR_ADDR: begin
          // Address and data channels complete independently, in either order.
          if (aw_pend && bus.awready) aw_pend <= 1'b0;
          if (w_pend && bus.wready)   w_pend  <= 1'b0;
          if ((!aw_pend || bus.awready) && (!w_pend || bus.wready)) state <= WR_RESP;
        end
        WR_RESP: begin
          if (bus.bvalid) begin
            bus.data_done <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: fetch, tie-break, split-handshake store,
// read backpressure and reset during a read.
module tb_axi_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  axi_arbiter_if bus ();

  axi_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs for the new cycle are set next.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.inst_req = 1'b0;  bus.inst_addr = '0;
    bus.data_req = 1'b0;  bus.data_wr = 1'b0;  bus.data_addr = '0;
    bus.data_wdata = '0;  bus.data_wstrb = '0;
    bus.arready = 1'b0;   bus.rdata = '0;      bus.rvalid = 1'b0;
    bus.awready = 1'b0;   bus.wready = 1'b0;   bus.bvalid = 1'b0;

    #2;
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_inst_done", bus.inst_done, 0);
    check("rst_inst_rdata", bus.inst_rdata, 0);
    check("rst_araddr", bus.araddr, 0);
    check("rst_stall", bus.stallreq_axi, 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Single fetch, minimum latency
    step();
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC0_0000; bus.arready = 1'b1;
    settle();
    check("f_c0_arvalid", bus.arvalid, 0);
    check("f_c0_stall", bus.stallreq_axi, 1);
    step(); settle();
    check("f_c1_arvalid", bus.arvalid, 1);
    check("f_c1_araddr", bus.araddr, 32'hBFC0_0000);
    step();
    bus.rvalid = 1'b1; bus.rdata = 32'h3C1D_8000;
    settle();
    check("f_c2_rready", bus.rready, 1);
    check("f_c2_arvalid", bus.arvalid, 0);
    check("f_c2_done", bus.inst_done, 0);
    step();
    bus.rvalid = 1'b0;
    settle();
    check("f_c3_done", bus.inst_done, 1);
    check("f_c3_rdata", bus.inst_rdata, 32'h3C1D_8000);
    check("f_c3_stall", bus.stallreq_axi, 0);
    check("f_c3_data_done", bus.data_done, 0);
    step();
    bus.inst_req = 1'b0;
    settle();
    check("f_c4_done", bus.inst_done, 0);
    check("f_c4_arvalid", bus.arvalid, 0);
    check("f_c4_rdata_hold", bus.inst_rdata, 32'h3C1D_8000);

    // Simultaneous requests: data first, then fetch
    step();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1000_0040;
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h8000_1000;
    settle();
    check("s_c0_stall", bus.stallreq_axi, 1);
    step(); settle();
    check("s_c1_araddr", bus.araddr, 32'h8000_1000);
    check("s_c1_arvalid", bus.arvalid, 1);
    step();
    bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF;
    settle();
    step();
    bus.rvalid = 1'b0;
    settle();
    check("s_c3_data_done", bus.data_done, 1);
    check("s_c3_inst_done", bus.inst_done, 0);
    check("s_c3_data_rdata", bus.data_rdata, 32'hDEAD_BEEF);
    check("s_c3_inst_rdata_hold", bus.inst_rdata, 32'h3C1D_8000);
    check("s_c3_stall", bus.stallreq_axi, 1);
    step();
    bus.data_req = 1'b0;
    settle();
    check("s_c4_arvalid", bus.arvalid, 1);
    check("s_c4_araddr", bus.araddr, 32'h1000_0040);
    check("s_c4_data_done", bus.data_done, 0);
    step();
    bus.rvalid = 1'b1; bus.rdata = 32'h1122_3344;
    settle();
    step();
    bus.rvalid = 1'b0;
    settle();
    check("s_c6_inst_done", bus.inst_done, 1);
    check("s_c6_inst_rdata", bus.inst_rdata, 32'h1122_3344);
    check("s_c6_data_rdata_hold", bus.data_rdata, 32'hDEAD_BEEF);
    step();
    bus.inst_req = 1'b0;
    bus.arready = 1'b0;
    settle();

    // Store with split handshakes
    step();
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_addr = 32'h8000_2000;
    bus.data_wdata = 32'hCAFE_F00D; bus.data_wstrb = 4'hF;
    settle();
    check("w_c0_awvalid", bus.awvalid, 0);
    step();
    bus.wready = 1'b1;
    settle();
    check("w_c1_awvalid", bus.awvalid, 1);
    check("w_c1_wvalid", bus.wvalid, 1);
    check("w_c1_awaddr", bus.awaddr, 32'h8000_2000);
    check("w_c1_wdata", bus.wdata, 32'hCAFE_F00D);
    check("w_c1_wstrb", bus.wstrb, 32'hF);
    step();
    bus.wready = 1'b0;
    settle();
    check("w_c2_wvalid", bus.wvalid, 0);
    check("w_c2_awvalid", bus.awvalid, 1);
    step();
    bus.awready = 1'b1;
    settle();
    check("w_c3_awvalid", bus.awvalid, 1);
    check("w_c3_bready", bus.bready, 0);
    step();
    bus.awready = 1'b0;
    settle();
    check("w_c4_awvalid", bus.awvalid, 0);
    check("w_c4_bready", bus.bready, 1);
    check("w_c4_done", bus.data_done, 0);
    step();
    bus.bvalid = 1'b1;
    settle();
    check("w_c5_bready", bus.bready, 1);
    check("w_c5_done", bus.data_done, 0);
    step();
    bus.bvalid = 1'b0;
    settle();
    check("w_c6_done", bus.data_done, 1);
    check("w_c6_bready", bus.bready, 0);
    check("w_c6_stall", bus.stallreq_axi, 0);
    step();
    bus.data_req = 1'b0; bus.data_wr = 1'b0;
    settle();
    check("w_c7_done", bus.data_done, 0);
    check("w_c7_awvalid", bus.awvalid, 0);

    // Read address backpressure; inputs changed mid-transaction are ignored
    step();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h0040_0000; bus.arready = 1'b0;
    settle();
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 2) begin
        bus.inst_addr = 32'hFFFF_FFFF;
        bus.data_req  = 1'b1;
      end
      settle();
      check($sformatf("bp_c%0d_arvalid", i), bus.arvalid, 1);
      check($sformatf("bp_c%0d_araddr", i), bus.araddr, 32'h0040_0000);
      check($sformatf("bp_c%0d_stall", i), bus.stallreq_axi, 1);
    end
    step();
    bus.data_req = 1'b0;
    bus.arready = 1'b1;
    settle();
    check("bp_c5_arvalid", bus.arvalid, 1);
    step();
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hA5A5_A5A5;
    settle();
    check("bp_c6_rready", bus.rready, 1);
    step();
    bus.rvalid = 1'b0;
    settle();
    check("bp_c7_done", bus.inst_done, 1);
    check("bp_c7_rdata", bus.inst_rdata, 32'hA5A5_A5A5);
    step();
    bus.inst_req = 1'b0;
    settle();

    // Reset while in RD_DATA
    step();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_1234; bus.arready = 1'b1;
    settle();
    step(); settle();
    step();
    bus.arready = 1'b0;
    settle();
    check("r_pre_rready", bus.rready, 1);
    rst = 1'b1;
    bus.rvalid = 1'b1; bus.rdata = 32'hBAD0_BAD0;
    settle();
    check("r_rready", bus.rready, 0);
    check("r_arvalid", bus.arvalid, 0);
    check("r_inst_rdata", bus.inst_rdata, 0);
    check("r_data_rdata", bus.data_rdata, 0);
    check("r_araddr", bus.araddr, 0);
    check("r_awaddr", bus.awaddr, 0);
    check("r_wdata", bus.wdata, 0);
    check("r_wstrb", bus.wstrb, 0);
    step(); settle();
    check("r_inst_done", bus.inst_done, 0);
    check("r_data_done", bus.data_done, 0);
    bus.rvalid = 1'b0;
    rst = 1'b0;
    bus.arready = 1'b1;
    step(); settle();
    check("r_post_arvalid", bus.arvalid, 1);
    check("r_post_araddr", bus.araddr, 32'h0000_1234);
    check("r_post_done0", bus.inst_done, 0);
    step();
    bus.rvalid = 1'b1; bus.rdata = 32'h600D_600D;
    settle();
    step();
    bus.rvalid = 1'b0;
    settle();
    check("r_post_done", bus.inst_done, 1);
    check("r_post_rdata", bus.inst_rdata, 32'h600D_600D);
    step();
    bus.inst_req = 1'b0;
    settle();
    check("r_post_done_end", bus.inst_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
